// File: rtl/fetch_unit_pkg.sv
// Shared RV32I fetch types: FSM states, queue entry layout and reset PC.
package rv32i_types;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0060;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with push/pop/flush, head read and occupancy.
// Pointers wrap naturally; count is one bit wider than the pointers.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_wdata,
    output fetch_entry_t               o_head,
    output logic [$clog2(QDEPTH):0]    o_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [QDEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != CNT_W'(QDEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // NOTE: storage is not reset; the count alone decides which slots are
    // meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, memory read handshake, entry queue, redirects.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_read,
    output logic [31:0] inst_addr,
    input  logic        inst_resp,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [6:0]  dec_opcode,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7
);

    localparam int               CNT_W   = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic [31:0]      r_addr;
    logic [31:0]      w_addr_nxt;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic             w_take;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    fetch_entry_t     w_head;
    fetch_entry_t     w_wdata;
    fetch_entry_t     w_dec_entry;

    assign w_target   = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_fetch_pc + 32'd4;
    assign w_take     = (r_state == FETCH_REQ) && inst_resp && !redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_take && (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Redirect wins over both queue operations; a bypassed word taken by
    // decode in the same cycle never lands in the queue.
    assign w_push      = w_take && !(w_bypass && dec_ready);
    assign w_pop       = !redirect && dec_ready && (w_count != '0);
    assign w_count_nxt = redirect ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
    assign w_room      = w_count_nxt < DEPTH_C;
    assign w_wdata     = '{pc: r_fetch_pc, instr: inst_rdata};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    // r_addr holds the address of the outstanding request; in DRAIN it keeps
    // the stale address while r_fetch_pc already points at the new target.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        case (r_state)
            FETCH_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_target;
                    w_addr_nxt     = w_target;
                    w_state_nxt    = FETCH_REQ;
                end else if (w_room) begin
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_target;
                    if (inst_resp) begin
                        w_addr_nxt  = w_target;
                        w_state_nxt = FETCH_REQ;
                    end else begin
                        w_state_nxt = FETCH_DRAIN;
                    end
                end else if (inst_resp) begin
                    w_fetch_pc_nxt = w_pc_plus4;
                    if (w_room) begin
                        w_addr_nxt  = w_pc_plus4;
                        w_state_nxt = FETCH_REQ;
                    end else begin
                        w_state_nxt = FETCH_IDLE;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (redirect) w_fetch_pc_nxt = w_target;
                if (inst_resp) begin
                    w_addr_nxt  = redirect ? w_target : r_fetch_pc;
                    w_state_nxt = FETCH_REQ;
                end
            end
            default: w_state_nxt = FETCH_IDLE;
        endcase
    end

    assign inst_read = (r_state != FETCH_IDLE);
    assign inst_addr = r_addr;

    // Empty-queue outputs are forced to zero rather than exposing stale RAM.
    always_comb begin
        dec_valid   = (w_count != '0);
        w_dec_entry = w_head;
        if (w_bypass) begin
            dec_valid   = 1'b1;
            w_dec_entry = w_wdata;
        end
        if (!dec_valid) w_dec_entry = '0;
    end

    assign dec_pc     = w_dec_entry.pc;
    assign dec_instr  = w_dec_entry.instr;
    assign dec_opcode = w_dec_entry.instr[6:0];
    assign dec_funct3 = w_dec_entry.instr[14:12];
    assign dec_funct7 = w_dec_entry.instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against an in-order instruction-stream model and a simple memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;

    int n_vec = 0;
    int n_err = 0;

    // memory responder state
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          lat = 1;
    bit          lat_rand = 0;
    bit          mem_const = 0;
    bit          addr_ok = 1;
    int          resp_total = 0;

`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 1;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .inst_read   (inst_read),
        .inst_addr   (inst_addr),
        .inst_resp   (inst_resp),
        .inst_rdata  (inst_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr),
        .dec_opcode  (dec_opcode),
        .dec_funct3  (dec_funct3),
        .dec_funct7  (dec_funct7)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_const) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One cycle of the memory: answer an accepted request after its latency,
    // otherwise accept a newly raised request.
    task automatic mem_step();
        inst_resp  = 1'b0;
        inst_rdata = $urandom;
        addr_ok    = 1'b1;
        if (mem_busy) begin
            if (inst_read !== 1'b1 || inst_addr !== mem_addr) addr_ok = 1'b0;
            if (mem_wait <= 1) begin
                inst_resp  = 1'b1;
                inst_rdata = memf(mem_addr);
                mem_busy   = 1'b0;
                resp_total++;
            end else begin
                mem_wait--;
            end
        end else if (inst_read === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = inst_addr;
            mem_wait = lat_rand ? int'($urandom_range(1, 4)) : lat;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        inst_resp   = 1'b0;
        inst_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        mem_busy    = 1'b0;
        mem_wait    = 0;
        resp_total  = 0;
        lat_rand    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_vec++;
        if (inst_read !== 1'b0 || inst_addr !== 32'h60) begin
            n_err++;
            $display("FAIL reset_fetch: read=%b addr=%h expected read=0 addr=00000060", inst_read, inst_addr);
        end
        n_vec++;
        if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_dec: valid=%b pc=%h instr=%h expected 0/0/0", dec_valid, dec_pc, dec_instr);
        end
        tick();
        tick();
        rst = 1'b1;
        settle();
        n_vec++;
        if (inst_read !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_early_read: read=%b expected 0", inst_read);
        end
        tick();
        n_vec++;
        if (inst_read !== 1'b1 || inst_addr !== 32'h60) begin
            n_err++;
            $display("FAIL first_request: read=%b addr=%h expected 1/00000060", inst_read, inst_addr);
        end
    endtask

    task automatic test_first_fetch();
        int resp_cyc = -1;
        int cyc = 0;
        bit seen = 0;
        mem_const = 1'b1;
        lat = 1;
        dec_ready = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            mem_step();
            settle();
            if (inst_resp) resp_cyc = cyc;
            if (dec_valid === 1'b1) begin
                seen = 1;
                n_vec++;
                if (cyc - resp_cyc != EXP_LAT) begin
                    n_err++;
                    $display("FAIL first_latency: got %0d expected %0d", cyc - resp_cyc, EXP_LAT);
                end
                n_vec++;
                if (dec_pc !== 32'h60 || dec_instr !== 32'h0050_0093) begin
                    n_err++;
                    $display("FAIL first_entry: pc=%h instr=%h expected 00000060/00500093", dec_pc, dec_instr);
                end
                n_vec++;
                if (dec_opcode !== 7'h13 || dec_funct3 !== 3'h0 || dec_funct7 !== 7'h0) begin
                    n_err++;
                    $display("FAIL first_fields: op=%h f3=%h f7=%h expected 13/0/00", dec_opcode, dec_funct3, dec_funct7);
                end
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL first_timeout: dec_valid=0 expected 1 within 10 cycles");
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] got[$];
        dec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_step();
            settle();
            tick();
        end
        n_vec++;
        if (resp_total != 2 || inst_read !== 1'b0) begin
            n_err++;
            $display("FAIL stall_full: responses=%0d read=%b expected 2/0", resp_total, inst_read);
        end
        n_vec++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h60) begin
            n_err++;
            $display("FAIL stall_head: valid=%b pc=%h expected 1/00000060", dec_valid, dec_pc);
        end
        dec_ready = 1'b1;
        mem_step();
        settle();
        if (dec_valid === 1'b1) got.push_back(dec_pc);
        tick();
        n_vec++;
        if (inst_read !== 1'b1 || inst_addr !== 32'h68) begin
            n_err++;
            $display("FAIL resume_addr: read=%b addr=%h expected 1/00000068", inst_read, inst_addr);
        end
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            mem_step();
            settle();
            if (dec_valid === 1'b1) got.push_back(dec_pc);
            tick();
        end
        n_vec++;
        if (got.size() != 3) begin
            n_err++;
            $display("FAIL stream_count: got %0d entries expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got[i] !== 32'h60 + 32'(4 * i)) begin
                    n_err++;
                    $display("FAIL stream_pc%0d: got %h expected %h", i, got[i], 32'h60 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc_q[$];
        logic [31:0] pc_q[$];
        logic [31:0] ins_q[$];
        do_reset();
        mem_const = 1'b0;
        lat = 1;
        dec_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mem_step();
            settle();
            if (dec_valid === 1'b1) begin
                cyc_q.push_back(c);
                pc_q.push_back(dec_pc);
                ins_q.push_back(dec_instr);
            end
            tick();
        end
        n_vec++;
        if (cyc_q.size() < 15) begin
            n_err++;
            $display("FAIL b2b_count: got %0d entries expected at least 15", cyc_q.size());
        end
        for (int i = 0; i < pc_q.size(); i++) begin
            n_vec++;
            if (pc_q[i] !== 32'h60 + 32'(4 * i) || ins_q[i] !== memf(32'h60 + 32'(4 * i))) begin
                n_err++;
                $display("FAIL b2b_entry%0d: pc=%h instr=%h expected %h/%h", i, pc_q[i], ins_q[i],
                         32'h60 + 32'(4 * i), memf(32'h60 + 32'(4 * i)));
            end
            if (i > 0) begin
                n_vec++;
                if (cyc_q[i] - cyc_q[i-1] != 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles expected 2", i, cyc_q[i] - cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_redirect_pending();
        bit found = 0;
        bit stale = 0;
        bit seen = 0;
        do_reset();
        mem_const = 1'b0;
        lat = 3;
        dec_ready = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            mem_step();
            if (mem_busy && mem_wait == 3 && mem_addr == 32'h64) begin
                redirect    = 1'b1;
                redirect_pc = 32'h103;
                found       = 1;
            end
            settle();
            tick();
            redirect = 1'b0;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL redir_setup: request for 00000064 not seen");
        end
        n_vec++;
        if (dec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_flush: dec_valid=%b expected 0", dec_valid);
        end
        for (int i = 0; i < 10 && !stale; i++) begin
            mem_step();
            settle();
            n_vec++;
            if (inst_read !== 1'b1 || inst_addr !== 32'h64) begin
                n_err++;
                $display("FAIL drain_hold: read=%b addr=%h expected 1/00000064", inst_read, inst_addr);
            end
            stale = inst_resp;
            tick();
        end
        n_vec++;
        if (inst_read !== 1'b1 || inst_addr !== 32'h100 || dec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_refetch: read=%b addr=%h valid=%b expected 1/00000100/0", inst_read, inst_addr, dec_valid);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            mem_step();
            settle();
            if (dec_valid === 1'b1) begin
                seen = 1;
                n_vec++;
                if (dec_pc !== 32'h100 || dec_instr !== memf(32'h100)) begin
                    n_err++;
                    $display("FAIL redir_entry: pc=%h instr=%h expected 00000100/%h", dec_pc, dec_instr, memf(32'h100));
                end
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL redir_timeout: dec_valid=0 expected 1");
        end
    endtask

    task automatic test_redirect_with_resp();
        bit hit = 0;
        bit seen = 0;
        do_reset();
        mem_const = 1'b0;
        lat = 1;
        dec_ready = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            mem_step();
            if (inst_resp && resp_total == 2) begin
                redirect    = 1'b1;
                redirect_pc = 32'h200;
                hit         = 1;
            end
            settle();
            tick();
            redirect = 1'b0;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL redir_resp_setup: second response not seen");
        end
        n_vec++;
        if (dec_valid !== 1'b0 || inst_read !== 1'b1 || inst_addr !== 32'h200) begin
            n_err++;
            $display("FAIL redir_resp: valid=%b read=%b addr=%h expected 0/1/00000200", dec_valid, inst_read, inst_addr);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            mem_step();
            settle();
            if (dec_valid === 1'b1) begin
                seen = 1;
                n_vec++;
                if (dec_pc !== 32'h200 || dec_instr !== memf(32'h200)) begin
                    n_err++;
                    $display("FAIL redir_resp_entry: pc=%h instr=%h expected 00000200/%h", dec_pc, dec_instr, memf(32'h200));
                end
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL redir_resp_timeout: dec_valid=0 expected 1");
        end
    endtask

    task automatic test_reset_mid();
        bit pend = 0;
        bit seen = 0;
        do_reset();
        mem_const = 1'b0;
        lat = 3;
        dec_ready = 1'b0;
        for (int i = 0; i < 30 && !pend; i++) begin
            mem_step();
            pend = mem_busy && (mem_addr == 32'h64);
            settle();
            tick();
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (inst_read !== 1'b0 || inst_addr !== 32'h60 || dec_valid !== 1'b0 ||
            dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_values: read=%b addr=%h valid=%b pc=%h instr=%h expected 0/00000060/0/0/0",
                     inst_read, inst_addr, dec_valid, dec_pc, dec_instr);
        end
        mem_busy = 1'b0;
        tick();
        rst = 1'b1;
        inst_resp  = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        settle();
        tick();
        inst_resp = 1'b0;
        n_vec++;
        if (dec_valid !== 1'b0 || inst_read !== 1'b1 || inst_addr !== 32'h60) begin
            n_err++;
            $display("FAIL stale_ignored: valid=%b read=%b addr=%h expected 0/1/00000060", dec_valid, inst_read, inst_addr);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            mem_step();
            settle();
            if (dec_valid === 1'b1) begin
                seen = 1;
                n_vec++;
                if (dec_pc !== 32'h60 || dec_instr !== memf(32'h60)) begin
                    n_err++;
                    $display("FAIL midreset_entry: pc=%h instr=%h expected 00000060/%h", dec_pc, dec_instr, memf(32'h60));
                end
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL midreset_timeout: dec_valid=0 expected 1");
        end
    endtask

    // Model: decode must see an unbroken PC stream starting at the latest
    // redirect target (or the reset PC), each word equal to memory contents.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        int          n_cons = 0;
        do_reset();
        mem_const = 1'b0;
        lat_rand  = 1'b1;
        exp_pc    = 32'h60;
        for (int c = 0; c < 3000; c++) begin
            dec_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            mem_step();
            settle();
            n_vec++;
            if (!addr_ok || inst_addr[1:0] !== 2'b00) begin
                n_err++;
                $display("FAIL rnd_addr_hold: cycle %0d addr=%h expected stable %h", c, inst_addr, mem_addr);
            end
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (dec_valid === 1'b1 && dec_ready) begin
                exp_ins = memf(exp_pc);
                n_vec++;
                if (dec_pc !== exp_pc || dec_instr !== exp_ins || dec_opcode !== exp_ins[6:0] ||
                    dec_funct3 !== exp_ins[14:12] || dec_funct7 !== exp_ins[31:25]) begin
                    n_err++;
                    $display("FAIL rnd_entry: cycle %0d pc=%h instr=%h expected %h/%h", c, dec_pc, dec_instr, exp_pc, exp_ins);
                end
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            tick();
        end
        redirect = 1'b0;
        n_vec++;
        if (n_cons < 200) begin
            n_err++;
            $display("FAIL rnd_progress: consumed %0d expected at least 200", n_cons);
        end
    endtask

    initial begin
        rst         = 1'b1;
        inst_resp   = 1'b0;
        inst_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        #3;
        test_reset();
        test_first_fetch();
        test_fill_stall();
        test_back_to_back();
        test_redirect_pending();
        test_redirect_with_resp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I pipeline, sitting directly upstream of the decode control ROM. It holds the fetch PC, drives the instruction-memory read handshake, and buffers returned words in a small queue. It presents each instruction to decode with its PC and pre-split opcode/funct3/funct7 fields under a valid/ready handshake. It also accepts redirects (taken branches/jumps), flushing buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0060: first fetch address after reset.
- `QDEPTH`, default 2: instruction queue depth; power of two, ≥2.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_read`  out  1  read request; held with `inst_addr` stable until `inst_resp`.
- `inst_addr`  out  32  word-aligned fetch address.
- `inst_resp`  in  1  one-cycle pulse; `inst_rdata` valid that cycle.
- `inst_rdata`  in  32  returned instruction word.
- `redirect`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  new fetch target; bits [1:0] ignored (forced 0).
- `dec_ready`  in  1  decode accepts the head entry this cycle.
- `dec_valid`  out  1  head entry valid.
- `dec_pc`  out  32  PC of head instruction.
- `dec_instr`  out  32  head instruction word.
- `dec_opcode`  out  7  `rv32i_opcode` field, instr[6:0].
- `dec_funct3`  out  3  instr[14:12].
- `dec_funct7`  out  7  instr[31:25].

## Operation
- FSM `fetch_state_t`: IDLE (no request), REQ (request outstanding), DRAIN (outstanding request to discard).
- Occupancy rule: new request issued at an edge only if next-cycle occupancy < QDEPTH. At most one request outstanding; queue never exceeds QDEPTH.
- IDLE → REQ when room; `inst_addr` = fetch_pc.
- REQ, `inst_resp`, no redirect: push {fetch_pc, inst_rdata}; fetch_pc += 4 (wraps mod 2^32). Stay REQ with new address if room, else IDLE.
- REQ, `redirect`, no `inst_resp`: flush queue; fetch_pc ← redirect_pc; → DRAIN. `inst_read`/`inst_addr` stay unchanged until response.
- REQ, `redirect` and `inst_resp` same cycle: response discarded; flush; fetch_pc ← redirect_pc; → REQ at redirect_pc next cycle.
- DRAIN, `inst_resp`: discard data; → REQ at fetch_pc. DRAIN, `redirect`: update fetch_pc, stay DRAIN. Both together: take new target, → REQ.
- IDLE, `redirect`: flush, fetch_pc ← redirect_pc, → REQ.
- Redirect has priority over push and pop: in a redirect cycle the head is not considered consumed, even if `dec_valid && dec_ready`.
- Push and pop in the same cycle leave occupancy unchanged; pop when empty is ignored.
- `dec_*` fields are slices of the head entry; `dec_valid` = queue non-empty.

## Timing
- Reset values: `inst_read`=0, `inst_addr`=RESET_PC, `dec_valid`=0, `dec_pc`/`dec_instr`=0, queue empty, state IDLE, fetch_pc=RESET_PC.
- First `inst_read` is asserted after the first rising edge following reset deassertion.
- Response to `dec_valid` latency: 1 cycle (data registered into the queue).
- Redirect to new-target `inst_read`: 1 cycle if no request is pending, otherwise 1 cycle after the stale response.
- Back-to-back: with memory responding in 1 cycle and decode always ready, throughput is one instruction every 2 cycles (request, response).
- Reset asserted mid-request: immediate return to reset values. Any later stale `inst_resp` is ignored in IDLE.

## Configuration
- `FETCH_BYPASS_EN` defined: when the queue is empty and `inst_resp` arrives (no redirect), `dec_*` is driven combinationally from `inst_rdata`/fetch_pc with `dec_valid`=1 that cycle. If `dec_ready`, the entry is consumed without being written. Latency is 0 cycles.
- Undefined: no combinational path from `inst_rdata` to `dec_*`; latency is 1 cycle as above.

## Structure
- Add to `rv32i_types`: `fetch_state_t` enum; `fetch_entry_t` struct {pc, instr}; constant `FETCH_RESET_PC`.
- Sub-module `fetch_queue`: parameterised circular FIFO of `fetch_entry_t`. It has push/pop/flush, head read, and occupancy count. Pointers are log2(QDEPTH) bits wrapping naturally; count is log2(QDEPTH)+1 bits.

## Test plan
- Reset release, memory responding 1 cycle after each request with 32'h0050_0093 -> first request at 0x60; `dec_valid`, `dec_pc`=0x60, `dec_opcode`=7'h13, `dec_funct3`=0, `dec_funct7`=0.
- `dec_ready`=1, three responses -> `dec_pc` sequence 0x60, 0x64, 0x68; no entry lost or duplicated.
- `dec_ready`=0 -> queue holds 2 entries (0x60, 0x64), `inst_read` drops; raise `dec_ready` -> fetching resumes at 0x68.
- Redirect to 0x103 while the request for 0x64 is pending, response delayed 3 cycles -> stale word discarded; next `inst_addr`=0x100; `dec_pc`=0x100.
- `redirect` and `inst_resp` in the same cycle with one queued entry -> queue empty next cycle; the response is not pushed; request at redirect_pc issued next cycle.
- `rst` low mid-request, then released -> outputs at reset values; a stale `inst_resp` pulse is ignored; a fresh request is issued at 0x60.
